stage5_mt1_msg_builder: RTL and testbench
=========================================

// Module: stage5_mt1_msg_builder
// PURPOSE
//  Transmit-side counterpart of the stage-5 field extractor. Packs an MT1 field and a payload
//  into one message word, then sends it MSB byte first on a valid/ready byte stream.
//  Sits at the egress of the accelerator and feeds the outbound message link.
//  Rejects requests the far-end extractor would decode as "no message".
//  These are an MT1 equal to DEFAULT_MT1, or an illegal length.
// PARAMETERS
//  MSG_BITS     128    message word width; must be a multiple of 8
//  MT1_BITS     8      MT1 field width; occupies msg[MSG_BITS-1 -: MT1_BITS]
//  DEFAULT_MT1  8'hFF  reserved "default information" MT1 code, never transmitted
//  LEN_W        5      width of byte-length field; must hold MSG_BITS/8 (NBYTES)
// PORTS
//  clk          in   1                   rising-edge clock
//  rst          in   1                   asynchronous, active-high reset
//  fld_valid    in   1                   field request valid
//  fld_ready    out  1                   builder can accept a request
//  fld_mt1      in   MT1_BITS            MT1 field
//  fld_payload  in   MSG_BITS-MT1_BITS   remaining message bits, below MT1
//  fld_len      in   LEN_W               bytes to send, counted from MSB; legal 1..NBYTES
//  tx_valid     out  1                   output byte valid
//  tx_ready     in   1                   downstream accepts byte
//  tx_data      out  8                   output byte
//  tx_sof       out  1                   qualifies first byte of message
//  tx_eof       out  1                   qualifies last byte of message
//  drop_err     out  1                   1-cycle pulse: request rejected
//  msg_cnt      out  16                  messages fully sent; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE, fld_ready=1, tx_valid=0, tx_data=0,
//   tx_sof=0, tx_eof=0, drop_err=0, msg_cnt=0. Shift register and byte count go to 0.
//  States:
//   IDLE: fld_ready=1, tx_valid=0.
//   SEND: fld_ready=0, tx_valid=1.
//  Accept = fld_valid & fld_ready, sampled at a rising edge.
//   Legal (1<=fld_len<=NBYTES and fld_mt1!=DEFAULT_MT1):
//    sh <= {fld_mt1,fld_payload}; rem <= fld_len; first <= 1; go SEND.
//   Illegal: drop_err=1 for the next cycle; stay IDLE; no tx activity.
//  Latency: accept at edge N -> first byte has tx_valid=1 in cycle N+1.
//  SEND outputs: tx_data=sh[MSG_BITS-1 -: 8]; tx_sof=first; tx_eof=(rem==1).
//   All are registered and held stable while tx_valid & !tx_ready (no byte loss or change).
//  Byte handshake (tx_valid & tx_ready):
//   sh <= sh<<8; rem <= rem-1; first <= 0.
//   If rem==1: go IDLE and msg_cnt <= msg_cnt+1 (modulo 2^16).
//  tx_valid never depends combinationally on tx_ready.
//  Back-to-back: fld_ready rises the cycle after the eof handshake, giving at least one idle
//   cycle between messages. Requests arriving during SEND are held off by fld_ready=0.
//  fld_len==NBYTES sends the full word. fld_len==1 sends only the MT1 byte, so sof and eof
//   are both 1 on that byte.
//  Reset asserted mid-message: the message is abandoned and tx_valid drops asynchronously.
//   No eof is emitted and msg_cnt is cleared.
//  Bytes beyond fld_len are never driven onto tx_data.
// TESTING
//  1 fld_mt1=8'h12, payload=120'h0, fld_len=16, tx_ready=1 -> 16 bytes on consecutive cycles.
//    First byte 8'h12 with sof; last byte with eof; msg_cnt=1.
//  2 fld_mt1=8'hA5, fld_len=3, tx_ready toggling 1,0,0,1,... -> bytes A5,P0,P1.
//    tx_data/sof/eof held during stalls; eof only on P1.
//  3 fld_mt1=8'hFF (DEFAULT_MT1) with len 4; then len 0; then len 17 -> one drop_err pulse each.
//    tx_valid stays 0; msg_cnt unchanged.
//  4 fld_len=1, fld_mt1=8'h3C -> single byte 3C with sof=eof=1.
//    Next request accepted no earlier than 2 cycles later.
//  5 rst pulsed during byte 5 of a 16-byte message -> tx_valid=0 and msg_cnt=0 in the same cycle.
//    Next request sends from byte 0 with sof.
//  6 msg_cnt preloaded to 16'hFFFF via 65535 len-1 messages (or force), one more message sent
//    -> msg_cnt wraps to 0.

Source files
------------

// File: rtl/stage5_mt1_msg_builder.sv
// MT1 message builder: packs {MT1, payload} into one word and streams it MSB byte first.
// Requests the far-end extractor would read as "no message" are dropped with a one-cycle pulse.
module stage5_mt1_msg_builder #(
    parameter int              MSG_BITS    = 128,
    parameter int              MT1_BITS    = 8,
    parameter logic [MT1_BITS-1:0] DEFAULT_MT1 = 8'hFF,
    parameter int              LEN_W       = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_fld_valid,
    output logic                         o_fld_ready,
    input  logic [MT1_BITS-1:0]          i_fld_mt1,
    input  logic [MSG_BITS-MT1_BITS-1:0] i_fld_payload,
    input  logic [LEN_W-1:0]             i_fld_len,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_sof,
    output logic                         o_tx_eof,
    output logic                         o_drop_err,
    output logic [15:0]                  o_msg_cnt
);
    localparam logic [LEN_W-1:0] NBYTES = LEN_W'(MSG_BITS / 8);
    localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MSG_BITS-1:0]   r_sh;
    logic [LEN_W-1:0]      r_rem;
    logic                  r_first;
    logic                  r_drop;
    logic [15:0]           r_msg_cnt;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_hs;
    logic                  w_last;

    assign w_legal = (i_fld_len >= ONE) && (i_fld_len <= NBYTES) && (i_fld_mt1 != DEFAULT_MT1);
    assign w_last  = (r_rem == ONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_hs        = 1'b0;
        o_fld_ready = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_tx_sof    = 1'b0;
        o_tx_eof    = 1'b0;
        case (r_state)
            IDLE: begin
                o_fld_ready = 1'b1;
                w_accept    = i_fld_valid && w_legal;
                w_reject    = i_fld_valid && !w_legal;
                if (w_accept) w_state_nxt = SEND;
            end
            SEND: begin
                // Data is gated to zero outside SEND so stale shifted bits never appear.
                o_tx_valid = 1'b1;
                o_tx_data  = r_sh[MSG_BITS-1 -: 8];
                o_tx_sof   = r_first;
                o_tx_eof   = w_last;
                w_hs       = i_tx_ready;
                if (w_hs && w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh      <= '0;
            r_rem     <= '0;
            r_first   <= 1'b0;
            r_drop    <= 1'b0;
            r_msg_cnt <= 16'h0000;
        end else begin
            r_drop <= w_reject;
            if (w_accept) begin
                r_sh    <= {i_fld_mt1, i_fld_payload};
                r_rem   <= i_fld_len;
                r_first <= 1'b1;
            end else if (w_hs) begin
                r_sh    <= r_sh << 8;
                r_rem   <= r_rem - ONE;
                r_first <= 1'b0;
                if (w_last) r_msg_cnt <= r_msg_cnt + 16'd1;
            end
        end
    end

    assign o_drop_err = r_drop;
    assign o_msg_cnt  = r_msg_cnt;
endmodule

// File: tb/tb_stage5_mt1_msg_builder.sv
// Bench for stage5_mt1_msg_builder: table of requests plus random requests, checked
// byte by byte against the message word sliced MSB-first.
module tb_stage5_mt1_msg_builder;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_fld_valid = 1'b0;
    logic         o_fld_ready;
    logic [7:0]   i_fld_mt1 = 8'h00;
    logic [119:0] i_fld_payload = '0;
    logic [4:0]   i_fld_len = 5'd0;
    logic         o_tx_valid;
    logic         i_tx_ready = 1'b0;
    logic [7:0]   o_tx_data;
    logic         o_tx_sof;
    logic         o_tx_eof;
    logic         o_drop_err;
    logic [15:0]  o_msg_cnt;

    stage5_mt1_msg_builder dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_fld_valid(i_fld_valid), .o_fld_ready(o_fld_ready),
        .i_fld_mt1(i_fld_mt1), .i_fld_payload(i_fld_payload), .i_fld_len(i_fld_len),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
        .o_tx_sof(o_tx_sof), .o_tx_eof(o_tx_eof),
        .o_drop_err(o_drop_err), .o_msg_cnt(o_msg_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]   mt1;
        logic [119:0] pl;
        int           len;
        int           mode;   // 0: always ready, 1: random ready, 2: ready 1,0,0 repeating
        bit           legal;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit model_legal(input logic [7:0] mt1, input int len);
        return (len >= 1) && (len <= 16) && (mt1 != 8'hFF);
    endfunction

    task automatic run_msg(input logic [7:0] mt1, input logic [119:0] pl, input int len,
                           input int mode, input bit legal);
        logic [127:0] w;
        int idx, cyc;
        bit r;
        w = {mt1, pl};
        chk("ready_idle", {31'd0, o_fld_ready}, 32'd1);
        i_fld_valid = 1'b1; i_fld_mt1 = mt1; i_fld_payload = pl; i_fld_len = 5'(len);
        @(posedge i_clk); #1;
        i_fld_valid = 1'b0;
        if (!legal) begin
            chk("drop_pulse", {29'd0, o_drop_err, o_tx_valid, o_fld_ready}, 32'b101);
            @(posedge i_clk); #1;
            chk("drop_clear", {30'd0, o_drop_err, o_tx_valid}, 32'd0);
            chk("cnt_after_drop", {16'd0, o_msg_cnt}, {16'd0, exp_cnt});
            return;
        end
        idx = 0; cyc = 0;
        while (idx < len && cyc < 400) begin
            r = (mode == 0) ? 1'b1 : (mode == 2) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            i_tx_ready = r;
            chk("byte", {20'd0, o_tx_valid, o_fld_ready, o_tx_sof, o_tx_eof, o_tx_data},
                {20'd0, 1'b1, 1'b0, idx == 0, idx == len - 1, w[127 - 8*idx -: 8]});
            @(posedge i_clk); #1;
            if (r) idx++;
            cyc++;
        end
        i_tx_ready = 1'b0;
        if (cyc >= 400) begin
            total++; bad++;
            $display("FAIL byte_timeout: got %0d bytes want %0d", idx, len);
        end
        exp_cnt++;
        chk("post_msg", {28'd0, o_tx_valid, o_fld_ready, o_tx_sof, o_tx_eof}, 32'b0100);
        chk("msg_cnt", {16'd0, o_msg_cnt}, {16'd0, exp_cnt});
    endtask

    initial begin
        vec_t tbl[8];
        logic [119:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        tbl[0] = '{8'h12, 120'h0, 16, 0, 1'b1};
        tbl[1] = '{8'hA5, p,      3,  2, 1'b1};
        tbl[2] = '{8'hFF, p,      4,  0, 1'b0};
        tbl[3] = '{8'h34, p,      0,  0, 1'b0};
        tbl[4] = '{8'h34, p,      17, 0, 1'b0};
        tbl[5] = '{8'h3C, p,      1,  0, 1'b1};
        tbl[6] = '{8'h00, ~p,     16, 1, 1'b1};
        tbl[7] = '{8'hFE, p,      8,  2, 1'b1};

        #1;
        chk("reset_vals", {7'd0, o_fld_ready, o_tx_valid, o_tx_data, o_tx_sof, o_tx_eof,
            o_drop_err, o_msg_cnt}, {7'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0});
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        for (int i = 0; i < 8; i++)
            run_msg(tbl[i].mt1, tbl[i].pl, tbl[i].len, tbl[i].mode, tbl[i].legal);

        // Back-to-back single-byte messages: second request waits for the idle cycle.
        run_msg(8'h3C, p, 1, 0, 1'b1);
        run_msg(8'h3D, p, 1, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] m;
            int l;
            m = (i % 7 == 0) ? 8'hFF : 8'($urandom);
            l = $urandom_range(0, 18);
            run_msg(m, {$urandom, $urandom, $urandom, $urandom}, l, 1, model_legal(m, l));
        end

        // Reset mid-message while byte 5 is on the bus.
        chk("cnt_nonzero_before_rst", {31'd0, o_msg_cnt != 16'h0}, 32'd1);
        i_fld_valid = 1'b1; i_fld_mt1 = 8'h77; i_fld_payload = p; i_fld_len = 5'd16;
        @(posedge i_clk); #1;
        i_fld_valid = 1'b0; i_tx_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("byte5_data", {24'd0, o_tx_data}, {24'd0, p[119-24 -: 8]});
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_async", {14'd0, o_tx_valid, o_fld_ready, o_msg_cnt}, {14'd0, 1'b0, 1'b1, 16'h0});
        i_tx_ready = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        exp_cnt = 16'h0;
        run_msg(8'h81, p, 16, 0, 1'b1);

        // Counter wrap: preload to all-ones, then send one more message.
        force dut.r_msg_cnt = 16'hFFFF;
        #1;
        release dut.r_msg_cnt;
        exp_cnt = 16'hFFFF;
        chk("cnt_preload", {16'd0, o_msg_cnt}, 32'h0000FFFF);
        run_msg(8'h01, p, 2, 0, 1'b1);
        chk("cnt_wrapped", {16'd0, o_msg_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
